event_source: RTL and testbench
===============================

# event_source

Stimulus transmitter for the event-counting monitor interface: drives `en` under `ready` backpressure to issue a programmed number of events, with an optional LFSR-based throttle. After the last event it waits for the monitor's `count_valid`, then compares the monitor `count` against the expected value. It sits opposite the monitor in on-chip self-test and timing-closure experiments, and produces a pass/fail result plus a timeout flag.

## Interface
- `COUNTER_WIDTH`, 64, width of `num_events`, `count`, and the internal sent/expected counters.
- `SETTLE_CYCLES`, 4, minimum cycles spent in DRAIN before `count_valid` is sampled; must be ≥ 1.
- `TIMEOUT_CYCLES`, 4096, maximum cycles allowed in WAIT_BASE or DRAIN before the run aborts.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `go` in 1: start pulse; sampled only in IDLE or DONE.
- `num_events` in COUNTER_WIDTH: number of events to send; captured at `go`.
- `duty` in 4: throttle level; captured at `go`; 0 means full rate.
- `seed` in 16: LFSR seed; captured at `go`; a value of 0 is replaced by 16'hACE1.
- `en` out 1: event offer to the monitor.
- `ready` in 1: monitor can accept an event.
- `count` in COUNTER_WIDTH: monitor running count.
- `count_valid` in 1: monitor count is settled.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: result valid; held until the next accepted `go`.
- `pass` out 1: final count matched the expected value; meaningful only while `done`=1.
- `timeout` out 1: run aborted on timeout; meaningful only while `done`=1.
- `sent` out COUNTER_WIDTH: events transferred in the current run.

## Operation
- A transfer occurs on any cycle with `en` && `ready`. `sent` increments on each transfer.
- States:
  - IDLE: `go` captures `num_events`, `duty`, and `seed`, clears `sent`, `done`, `pass`, `timeout` and the timeout counter, then moves to WAIT_BASE.
  - WAIT_BASE: on the first cycle with `count_valid`=1, capture `base` = `count`. Go to DRAIN if `num_events`=0, otherwise to SEND.
  - SEND: offer events. Leave for DRAIN on the cycle of the transfer that makes `sent` equal `num_events`.
  - DRAIN: wait at least SETTLE_CYCLES. Then, on the first cycle with `count_valid`=1, set `pass` = (`count` == `base` + `num_events` mod 2^COUNTER_WIDTH) and go to DONE.
  - DONE: `done`=1. `go` behaves exactly as in IDLE.
- Throttle:
  - 16-bit Fibonacci LFSR, shift left, feedback = l[15]^l[13]^l[12]^l[10].
  - The LFSR advances every SEND cycle in which no offer is pending.
  - A new offer starts when `lfsr[3:0]` >= `duty`. With `duty`=0, `en` is high every SEND cycle.
- Offer hold: once `en` is high it stays high until the transfer completes. `en` never drops while `ready`=0.
- `en` is 0 in every state other than SEND. No event is ever sent beyond `num_events`.
- Timeout: a counter runs in WAIT_BASE and DRAIN. On reaching TIMEOUT_CYCLES it forces DONE with `pass`=0 and `timeout`=1. SEND has no timeout, because backpressure may be unbounded.
- All arithmetic is modulo 2^COUNTER_WIDTH, so wraparound of `base` + `num_events` is legal.
- `go` while `busy` is ignored.

## Timing
- Reset values: `en`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `sent`=0; state is IDLE and the LFSR holds 16'hACE1.
- Reset is honoured mid-run: all outputs return to their reset values asynchronously, and any pending offer is dropped.
- `go` at edge N puts the block in WAIT_BASE at N+1. With `count_valid`=1 the block is in SEND at N+2, so the first `en` is high in the cycle after N+2.
- With `duty`=0 and `ready` held at 1, one event transfers per cycle: K events occupy K consecutive cycles.
- The final transfer and the move to DRAIN happen on the same edge. `en` is 0 in the following cycle.
- DRAIN lasts at least SETTLE_CYCLES cycles, so `done` rises no earlier than SETTLE_CYCLES+1 edges after the final transfer.
- `sent`, `done`, `pass` and `timeout` are all registered outputs.

## Test plan
- Full rate: `num_events`=10, `duty`=0, `ready`=1, ideal monitor starting at count 0 → `en` high for exactly 10 consecutive cycles, `sent`=10, `done`=1, `pass`=1.
- Backpressure: drive `ready` low for 5 cycles in the middle of the run while `en` is high → `en` stays high throughout, no transfer is lost or duplicated, the final `sent`=`num_events`, and `pass`=1.
- Mismatch and timeout: a monitor model that drops one event gives `pass`=0 and `timeout`=0. A model with `count_valid` stuck at 0 gives `done` after TIMEOUT_CYCLES with `timeout`=1.
- Edge cases:
  - `num_events`=0 → no `en` pulse and `pass`=1.
  - Base count 2^64−3 with `num_events`=5 → expected count 2, `pass`=1.
- Throttle: `duty`=15, `seed`=1, `num_events`=32 → offers at about 1/16 rate, `pass`=1. A repeated run with the same seed produces an identical `en` trace. `seed`=0 behaves identically to `seed`=16'hACE1.
- Reset mid-SEND: assert `rst` after 3 transfers → `en`, `busy` and `sent` clear immediately. A new `go` then completes a fresh run with `pass`=1.

Source files
------------

// File: rtl/event_source.sv
// event_source
//   Stimulus transmitter for an event-counting monitor. It offers a programmed
//   number of events on `en`/`ready` and can throttle them with an LFSR. It then
//   waits for the monitor's count to settle and checks it against base + num_events.
//
// Parameters
//   COUNTER_WIDTH   width of num_events / count / sent and internal counters
//   SETTLE_CYCLES   minimum DRAIN cycles before count_valid is sampled (>= 1)
//   TIMEOUT_CYCLES  cycles allowed in WAIT_BASE or DRAIN before aborting
//
// Ports
//   clk, rst              clock, async active-high reset
//   go                    start pulse (accepted in IDLE/DONE only)
//   num_events/duty/seed  run setup, captured on an accepted go
//   en / ready            event offer / monitor accept; transfer = en && ready
//   count / count_valid   monitor running count and its settled flag
//   busy                  run in progress (not IDLE, not DONE)
//   done/pass/timeout     registered result, held until the next accepted go
//   sent                  events transferred in the current run
module event_source #(
  parameter int COUNTER_WIDTH  = 64,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic [COUNTER_WIDTH-1:0] num_events,
  input  logic [3:0]               duty,
  input  logic [15:0]              seed,
  output logic                     en,
  input  logic                     ready,
  input  logic [COUNTER_WIDTH-1:0] count,
  input  logic                     count_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [COUNTER_WIDTH-1:0] sent
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] SEED_DEF = 16'hACE1;

  typedef enum logic [2:0] {IDLE, WAIT_BASE, SEND, DRAIN, DONE} state_t;

  state_t                   state, state_nx;
  logic [COUNTER_WIDTH-1:0] n_ev, base, sent_inc;
  logic [3:0]               duty_r;
  logic [15:0]              lfsr, lfsr_nx;
  logic                     pend;
  logic [TW-1:0]            tcnt;
  logic                     tmo_hit, settled;

  assign sent_inc = sent + 1'b1;
  assign lfsr_nx  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign busy     = (state != IDLE) && (state != DONE);
  // One counter serves both the timeout and the DRAIN settle window; it is
  // cleared on entry to DRAIN so each waiting state gets its own budget.
  assign tmo_hit  = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign settled  = (tcnt >= TW'(SETTLE_CYCLES));

  always_comb begin
    state_nx = state;
    en       = 1'b0;
    case (state)
      IDLE, DONE: if (go) state_nx = WAIT_BASE;
      WAIT_BASE: begin
        if (count_valid)  state_nx = (n_ev == '0) ? DRAIN : SEND;
        else if (tmo_hit) state_nx = DONE;
      end
      SEND: begin
        // A held offer always wins; otherwise the LFSR decides whether to offer.
        en = pend | (lfsr[3:0] >= duty_r);
        if (en && ready && (sent_inc == n_ev)) state_nx = DRAIN;
      end
      DRAIN: if ((settled && count_valid) || tmo_hit) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n_ev    <= '0;
      base    <= '0;
      duty_r  <= '0;
      lfsr    <= SEED_DEF;
      pend    <= 1'b0;
      tcnt    <= '0;
      sent    <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, DONE: begin
          if (go) begin
            n_ev    <= num_events;
            duty_r  <= duty;
            lfsr    <= (seed == 16'h0) ? SEED_DEF : seed;
            pend    <= 1'b0;
            tcnt    <= '0;
            sent    <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        WAIT_BASE: begin
          if (count_valid) begin
            base <= count;
            tcnt <= '0;
          end else if (tmo_hit) begin
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SEND: begin
          if (!pend) lfsr <= lfsr_nx;
          pend <= en & ~ready;
          if (en && ready) sent <= sent_inc;
        end
        DRAIN: begin
          if (settled && count_valid) begin
            done <= 1'b1;
            pass <= (count == base + n_ev);
          end else if (tmo_hit) begin
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_event_source.sv
module tb_event_source;
  localparam int CW = 64;
  localparam int SC = 4;
  localparam int TC = 4096;
  localparam int WD = 6000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [CW-1:0] num_events = '0;
  logic [3:0]    duty = '0;
  logic [15:0]   seed = '0;
  logic          en;
  logic          ready = 1'b1;
  logic [CW-1:0] count;
  logic          count_valid;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] sent;

  // driver-owned knobs
  logic [CW-1:0] base_req = '0;
  bit            drop_req = 1'b0;
  bit            stuck = 1'b0;

  // monitor-owned ideal count model
  logic [CW-1:0] mon_cnt = '0;
  assign count       = mon_cnt;
  assign count_valid = !stuck;

  always #5 clk = ~clk;

  event_source #(.COUNTER_WIDTH(CW), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .go(go), .num_events(num_events), .duty(duty), .seed(seed),
    .en(en), .ready(ready), .count(count), .count_valid(count_valid), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .sent(sent)
  );

  typedef struct {
    logic [CW-1:0] sent;
    bit pass;
    bit tmo;
    bit full10;
    bit settle;
    bit slow;
    bit zero_en;
    bit tmo_time;
    int save_slot;
    int cmp_slot;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: the monitor ends at base + delivered events; the run
  // passes only if that equals base + n. A stuck count_valid means no
  // transfers at all and a timeout.
  function automatic exp_t mk_exp(input logic [CW-1:0] n, input logic [CW-1:0] b,
                                  input bit drp, input bit stk);
    exp_t e;
    logic [CW-1:0] delivered, final_cnt;
    delivered   = stk ? '0 : (drp ? n - 1 : n);
    final_cnt   = b + delivered;
    e.sent      = stk ? '0 : n;
    e.pass      = !stk && (final_cnt == b + n);
    e.tmo       = stk;
    e.full10    = 1'b0;
    e.settle    = !stk && (n != 0);
    e.slow      = 1'b0;
    e.zero_en   = (n == 0);
    e.tmo_time  = stk;
    e.save_slot = -1;
    e.cmp_slot  = -1;
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  // Monitor / scoreboard: all comparisons live here.
  initial begin
    bit            active = 0, done_q = 0, prev_hold = 0, drop_arm = 0;
    int            wd = 0, en_cycles = 0, first_en = -1, last_en = 0, last_xfer = 0, go_edge = 0, tlen = 0;
    logic [CW-1:0] xfer_cnt = '0;
    logic [63:0]   sig = '0;
    logic [63:0]   saved_sig [4];
    int            saved_len [4];
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_sent", sent, 0);
        active = 0; done_q = 0; prev_hold = 0;
      end else begin
        if (!busy) chk("en_low_when_idle", en, 0);
        if (prev_hold) chk("en_hold_under_backpressure", en, 1);
        prev_hold = en && !ready;
        if (go && !busy) begin
          mon_cnt = base_req; drop_arm = drop_req; xfer_cnt = '0;
          en_cycles = 0; first_en = -1; last_en = 0; last_xfer = 0;
          sig = '0; tlen = 0; wd = 0; go_edge = cyc + 1;
          active = (exp_q.size() > 0);
        end
        if (busy) begin
          sig = sig * 64'd1000003 + {63'd0, en} + 64'd1;
          tlen++;
          if (en) begin
            en_cycles++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
          end
        end
        if (en && ready) begin
          if (drop_arm) drop_arm = 0;
          else mon_cnt = mon_cnt + 1;
          xfer_cnt = xfer_cnt + 1;
          last_xfer = cyc;
        end
        if (active && done && !done_q) begin
          e = exp_q.pop_front();
          chk("sent", sent, e.sent);
          chk("pass", pass, e.pass);
          chk("timeout", timeout, e.tmo);
          chk("transfers_seen", xfer_cnt, e.sent);
          chk("busy_at_done", busy, 0);
          if (e.full10) begin
            chk("full_rate_en_cycles", en_cycles, 10);
            chk("full_rate_consecutive", last_en - first_en + 1, 10);
            chk("first_en_latency_ok", (first_en - go_edge >= 1) && (first_en - go_edge <= 2), 1);
          end
          if (e.settle) chk("settle_gap_ok", (cyc - last_xfer - 1) >= SC + 1, 1);
          if (e.slow) chk("throttle_slow", (last_en - first_en) >= 64, 1);
          if (e.zero_en) chk("no_en_pulse", en_cycles, 0);
          if (e.tmo_time) chk("timeout_not_early", (cyc - go_edge) >= TC, 1);
          if (e.save_slot >= 0) begin
            saved_sig[e.save_slot] = sig;
            saved_len[e.save_slot] = tlen;
          end
          if (e.cmp_slot >= 0) begin
            chk("trace_len_repeat", tlen, saved_len[e.cmp_slot]);
            chk("trace_sig_repeat", sig, saved_sig[e.cmp_slot]);
          end
          active = 0;
        end else if (active) begin
          wd++;
          if (wd > WD) begin
            n_checks++; n_fails++;
            $display("FAIL watchdog: done not seen within %0d cycles (cycle %0d)", WD, cyc);
            void'(exp_q.pop_front());
            active = 0;
          end
        end
        done_q = done;
      end
    end
  end

  // mode: 0 ready high, 1 five-cycle backpressure mid-run, 2 random ready
  task automatic run(input logic [CW-1:0] n, input logic [3:0] d, input logic [15:0] s,
                     input logic [CW-1:0] b, input bit drp, input bit stk, input exp_t e, input int mode);
    int k;
    base_req = b; drop_req = drp; stuck = stk;
    num_events = n; duty = d; seed = s;
    exp_q.push_back(e);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    if (mode == 1) begin
      repeat (4) @(posedge clk);
      #1 ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 ready = 1'b1;
    end
    k = 0;
    while (!done && k < 8000) begin
      if (mode == 2) ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      k++;
    end
    ready = 1'b1; stuck = 1'b0; drop_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [CW-1:0] n, b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    e = mk_exp(10, 0, 0, 0); e.full10 = 1;
    run(10, 0, 16'h1234, 0, 0, 0, e, 0);

    e = mk_exp(20, 64'd100, 0, 0);
    run(20, 0, 16'h0042, 64'd100, 0, 0, e, 1);

    e = mk_exp(12, 64'd7, 1, 0);
    run(12, 0, 16'h0042, 64'd7, 1, 0, e, 0);

    e = mk_exp(5, 0, 0, 1);
    run(5, 0, 16'h0042, 0, 0, 1, e, 0);

    e = mk_exp(0, 64'd55, 0, 0);
    run(0, 0, 16'h0042, 64'd55, 0, 0, e, 0);

    b = 64'hFFFF_FFFF_FFFF_FFFD;
    e = mk_exp(5, b, 0, 0);
    run(5, 0, 16'h0042, b, 0, 0, e, 0);

    e = mk_exp(32, 0, 0, 0); e.slow = 1; e.save_slot = 0;
    run(32, 15, 16'h0001, 0, 0, 0, e, 0);
    e = mk_exp(32, 0, 0, 0); e.slow = 1; e.cmp_slot = 0;
    run(32, 15, 16'h0001, 0, 0, 0, e, 0);

    e = mk_exp(20, 0, 0, 0); e.save_slot = 1;
    run(20, 8, 16'h0000, 0, 0, 0, e, 0);
    e = mk_exp(20, 0, 0, 0); e.cmp_slot = 1;
    run(20, 8, 16'hACE1, 0, 0, 0, e, 0);

    // Reset three transfers into a run; no result is expected from it.
    base_req = '0; drop_req = 0; stuck = 0;
    num_events = 10; duty = 0; seed = 16'h0007;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    e = mk_exp(10, 64'd3, 0, 0);
    run(10, 0, 16'h0007, 64'd3, 0, 0, e, 0);

    for (int i = 0; i < 6; i++) begin
      bit drp;
      logic [3:0] d;
      logic [15:0] s;
      n   = CW'($urandom_range(1, 40));
      b   = {$urandom, $urandom};
      drp = 1'($urandom_range(0, 1));
      d   = 4'($urandom_range(0, 15));
      s   = 16'($urandom);
      e   = mk_exp(n, b, drp, 0);
      run(n, d, s, b, drp, 0, e, 2);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
